// File: rtl/dma_pkg.sv
// Shared AXI/DMA types for the read-side burst responder.
package dma_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] axi_addr_t;
    typedef logic [LEN_W-1:0]  axi_len_t;
    typedef logic [STRB_W-1:0] axi_strb_t;
    typedef logic [2:0]        axi_size_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        axi_addr_t addr;
        axi_len_t  alen;
        axi_strb_t strb;
    } s_dma_burst_info_t;

    typedef enum logic [1:0] {
        DMA_RRESP_ERR      = 2'd0,
        DMA_LAST_EARLY_ERR = 2'd1,
        DMA_LAST_MISS_ERR  = 2'd2
    } dma_rd_err_e;

endpackage

// File: rtl/dma_burst_info_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a zero-latency head view.
module dma_burst_info_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rstn,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_eff, pop_eff;

    assign push_eff = push_i & ~full_q;
    assign pop_eff  = pop_i & ~empty_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop_eff) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push_eff, pop_eff})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_eff) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/dma_rd_burst_responder.sv
// DMA read front end: issues streamer bursts on AXI AR, forwards R beats with
// per-burst strobe/last, and latches the first beat-count or response error.
module dma_rd_burst_responder
    import dma_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LEN_W-1:0]  req_alen_i,
    input  logic [2:0]        req_size_i,
    input  logic [STRB_W-1:0] req_strb_i,
    output logic              req_ready_o,
    output logic              arvalid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [LEN_W-1:0]  arlen_o,
    output logic [2:0]        arsize_o,
    output logic [1:0]        arburst_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rlast_i,
    output logic              rready_o,
    output logic              dat_valid_o,
    output logic [DATA_W-1:0] dat_data_o,
    output logic [STRB_W-1:0] dat_strb_o,
    output logic              dat_last_o,
    input  logic              dat_ready_i,
    output logic              busy_o,
    output logic              err_valid_o,
    output logic [1:0]        err_src_o,
    output logic [ADDR_W-1:0] err_addr_o,
    input  logic              err_clr_i
);

    localparam int unsigned BEAT_W = LEN_W + 1;

    s_dma_burst_info_t push_entry;
    s_dma_burst_info_t head;
    logic              info_full, info_empty;
    logic              accept, r_hs, exp_last, pop;

    logic              arvalid_q, arvalid_d;
    axi_addr_t         araddr_q, araddr_d;
    axi_len_t          arlen_q, arlen_d;
    axi_size_t         arsize_q, arsize_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              err_valid_q, err_valid_d;
    dma_rd_err_e       err_src_q, err_src_d;
    axi_addr_t         err_addr_q, err_addr_d;
    logic              unused_rresp0;

    // DECERR and SLVERR both have bit 1 set; bit 0 carries no extra meaning here.
    assign unused_rresp0 = rresp_i[0];

    assign req_ready_o = (~arvalid_q | arready_i) & ~info_full;
    assign accept      = req_valid_i & req_ready_o;
    assign push_entry  = '{addr: req_addr_i, alen: req_alen_i, strb: req_strb_i};

    dma_burst_info_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (s_dma_burst_info_t)
    ) u_info_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (info_full),
        .empty_o (info_empty)
    );

    // R path is a pure pass-through gated by having a burst to attribute beats to.
    assign rready_o    = dat_ready_i & ~info_empty;
    assign dat_valid_o = rvalid_i & ~info_empty;
    assign dat_data_o  = rdata_i;
    assign r_hs        = rvalid_i & rready_o;
    assign exp_last    = ~info_empty & (beat_q == {1'b0, head.alen});
    assign pop         = r_hs & exp_last;
    assign dat_last_o  = exp_last;
    assign dat_strb_o  = (head.alen == '0) ? head.strb : '1;

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        if (accept) begin
            arvalid_d = 1'b1;
            araddr_d  = req_addr_i;
            arlen_d   = req_alen_i;
            arsize_d  = req_size_i;
        end else if (arready_i) begin
            arvalid_d = 1'b0;
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = '0;
        end else if (r_hs) begin
            beat_d = BEAT_W'(beat_q + 1'b1);
        end
    end

    // First error wins; a coincident clear discards the new error.
    always_comb begin
        err_valid_d = err_valid_q;
        err_src_d   = err_src_q;
        err_addr_d  = err_addr_q;
        if (err_clr_i) begin
            err_valid_d = 1'b0;
        end else if (!err_valid_q && r_hs) begin
            if (rresp_i[1]) begin
                err_valid_d = 1'b1;
                err_src_d   = DMA_RRESP_ERR;
                err_addr_d  = head.addr;
            end else if (rlast_i && !exp_last) begin
                err_valid_d = 1'b1;
                err_src_d   = DMA_LAST_EARLY_ERR;
                err_addr_d  = head.addr;
            end else if (exp_last && !rlast_i) begin
                err_valid_d = 1'b1;
                err_src_d   = DMA_LAST_MISS_ERR;
                err_addr_d  = head.addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            beat_q      <= '0;
            err_valid_q <= 1'b0;
            err_src_q   <= DMA_RRESP_ERR;
            err_addr_q  <= '0;
        end else begin
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            beat_q      <= beat_d;
            err_valid_q <= err_valid_d;
            err_src_q   <= err_src_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign arvalid_o   = arvalid_q;
    assign araddr_o    = araddr_q;
    assign arlen_o     = arlen_q;
    assign arsize_o    = arsize_q;
    assign arburst_o   = AXI_BURST_INCR;
    assign busy_o      = arvalid_q | ~info_empty;
    assign err_valid_o = err_valid_q;
    assign err_src_o   = err_src_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_dma_rd_burst_responder.sv
// Bench for dma_rd_burst_responder: directed scenarios plus random traffic
// checked every cycle against a queue-based model of outstanding bursts.
module tb_dma_rd_burst_responder;
    import dma_pkg::*;

    localparam int unsigned MAXO = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [LEN_W-1:0]  req_alen_i;
    logic [2:0]        req_size_i;
    logic [STRB_W-1:0] req_strb_i;
    logic              req_ready_o;
    logic              arvalid_o;
    logic [ADDR_W-1:0] araddr_o;
    logic [LEN_W-1:0]  arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;
    logic              arready_i;
    logic              rvalid_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;
    logic              rready_o;
    logic              dat_valid_o;
    logic [DATA_W-1:0] dat_data_o;
    logic [STRB_W-1:0] dat_strb_o;
    logic              dat_last_o;
    logic              dat_ready_i;
    logic              busy_o;
    logic              err_valid_o;
    logic [1:0]        err_src_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic              err_clr_i;

    always #5 clk = ~clk;

    dma_rd_burst_responder #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_alen_i(req_alen_i),
        .req_size_i(req_size_i), .req_strb_i(req_strb_i), .req_ready_o(req_ready_o),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rready_o(rready_o),
        .dat_valid_o(dat_valid_o), .dat_data_o(dat_data_o), .dat_strb_o(dat_strb_o),
        .dat_last_o(dat_last_o), .dat_ready_i(dat_ready_i),
        .busy_o(busy_o),
        .err_valid_o(err_valid_o), .err_src_o(err_src_o), .err_addr_o(err_addr_o),
        .err_clr_i(err_clr_i)
    );

    // Reference model: accepted-but-unfinished bursts in order, plus AR slot and error latch.
    typedef struct {
        logic [31:0] addr;
        int          alen;
        logic [63:0] strb;
    } burst_t;

    burst_t      bq[$];
    int          beat;
    bit          ar_v;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    bit          err_v;
    int          err_src;
    logic [31:0] err_addr;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        beat  = 0;
        ar_v  = 1'b0;
        err_v = 1'b0;
        err_src  = 0;
        err_addr = '0;
    endtask

    task automatic set_idle();
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_alen_i  = '0;
        req_size_i  = 3'd6;
        req_strb_i  = '0;
        arready_i   = 1'b1;
        rvalid_i    = 1'b0;
        rdata_i     = '0;
        rresp_i     = 2'b00;
        rlast_i     = 1'b0;
        dat_ready_i = 1'b1;
        err_clr_i   = 1'b0;
    endtask

    task automatic rand_rdata();
        for (int i = 0; i < 16; i++) rdata_i[i*32 +: 32] = $urandom();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready_o, 1);
        check({tag, "_arvalid"},   arvalid_o, 0);
        check({tag, "_rready"},    rready_o, 0);
        check({tag, "_dat_valid"}, dat_valid_o, 0);
        check({tag, "_dat_last"},  dat_last_o, 0);
        check({tag, "_busy"},      busy_o, 0);
        check({tag, "_err_valid"}, err_valid_o, 0);
        check({tag, "_err_src"},   err_src_o, 0);
        check({tag, "_err_addr"},  err_addr_o, 0);
    endtask

    // Called at a falling edge with inputs already set: check, clock, update model.
    task automatic step();
        int          sz;
        bit          e_ready, acc, rhs, last;
        logic [63:0] e_strb;
        #1;
        sz      = bq.size();
        e_ready = (!ar_v || arready_i) && (sz < MAXO);
        last    = (sz > 0) && (beat == bq[0].alen);
        check("req_ready", req_ready_o, e_ready);
        check("arvalid", arvalid_o, ar_v);
        if (ar_v) begin
            check("araddr", araddr_o, ar_addr);
            check("arlen", arlen_o, ar_len);
            check("arsize", arsize_o, 6);
        end
        check("arburst", arburst_o, 1);
        check("rready", rready_o, dat_ready_i && sz > 0);
        check("dat_valid", dat_valid_o, rvalid_i && sz > 0);
        check("dat_data", dat_data_o, rdata_i);
        check("busy", busy_o, ar_v || sz > 0);
        check("dat_last", dat_last_o, last);
        if (sz > 0) begin
            e_strb = (bq[0].alen == 0) ? bq[0].strb : {64{1'b1}};
            check("dat_strb", dat_strb_o, e_strb);
        end
        check("err_valid", err_valid_o, err_v);
        if (err_v) begin
            check("err_src", err_src_o, err_src);
            check("err_addr", err_addr_o, err_addr);
        end
        @(posedge clk);
        acc = req_valid_i && e_ready;
        rhs = rvalid_i && dat_ready_i && sz > 0;
        if (err_clr_i) begin
            err_v = 1'b0;
        end else if (!err_v && rhs) begin
            if (rresp_i[1]) begin
                err_v = 1'b1; err_src = 0; err_addr = bq[0].addr;
            end else if (rlast_i && !last) begin
                err_v = 1'b1; err_src = 1; err_addr = bq[0].addr;
            end else if (last && !rlast_i) begin
                err_v = 1'b1; err_src = 2; err_addr = bq[0].addr;
            end
        end
        if (acc) begin
            ar_v = 1'b1; ar_addr = req_addr_i; ar_len = req_alen_i;
        end else if (arready_i) begin
            ar_v = 1'b0;
        end
        if (rhs) begin
            if (last) begin
                void'(bq.pop_front());
                beat = 0;
            end else begin
                beat++;
            end
        end
        if (acc) bq.push_back('{addr: req_addr_i, alen: int'(req_alen_i), strb: req_strb_i});
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] addr, input logic [7:0] alen, input logic [63:0] strb);
        req_valid_i = 1'b1; req_addr_i = addr; req_alen_i = alen; req_strb_i = strb;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        req_valid_i = 1'b0; arready_i = 1'b1; dat_ready_i = 1'b1; rresp_i = 2'b00;
        while ((bq.size() > 0 || ar_v) && n < 600) begin
            rvalid_i = bq.size() > 0;
            rlast_i  = (bq.size() > 0) && (beat == bq[0].alen);
            rand_rdata();
            step();
            n++;
        end
        rvalid_i = 1'b0; rlast_i = 1'b0;
        check(tag, busy_o, 0);
    endtask

    initial begin
        int acc_cnt;
        set_idle();
        model_reset();
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        // Single 4-beat burst.
        issue(32'h1000, 8'd3, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            rvalid_i = 1'b1; rlast_i = (i == 3); rand_rdata();
            step();
        end
        rvalid_i = 1'b0; rlast_i = 1'b0;
        check("single_busy_done", busy_o, 0);

        // Narrow single-beat burst uses the request strobe.
        issue(32'h2000, 8'd0, 64'h0000_0000_0000_FFF0);
        step();
        rvalid_i = 1'b1; rlast_i = 1'b1; rand_rdata();
        #1;
        check("narrow_strb", dat_strb_o, 64'h0000_0000_0000_FFF0);
        check("narrow_last", dat_last_o, 1);
        step();
        rvalid_i = 1'b0; rlast_i = 1'b0;

        // Outstanding limit: six offered, four taken.
        acc_cnt = 0;
        req_valid_i = 1'b1; req_alen_i = 8'd0; req_strb_i = '1;
        for (int i = 0; i < 6; i++) begin
            req_addr_i = 32'h8000 + 32'(i) * 32'h40;
            #1;
            if (req_valid_i && req_ready_o) acc_cnt++;
            step();
        end
        check("bp_accepts", acc_cnt, 4);
        check("bp_ready_low", req_ready_o, 0);
        rvalid_i = 1'b1; rlast_i = 1'b1; rand_rdata();
        step();
        rvalid_i = 1'b0; rlast_i = 1'b0;
        #1;
        check("bp_reready", req_ready_o, 1);
        step();
        drain("bp_drain");

        // AR stall keeps the slot stable and blocks new requests.
        arready_i = 1'b0;
        issue(32'h4000, 8'd2, '0);
        req_valid_i = 1'b1; req_addr_i = 32'h5000; req_alen_i = 8'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_araddr", araddr_o, 32'h4000);
            check("stall_ready", req_ready_o, 0);
        end
        req_valid_i = 1'b0; arready_i = 1'b1;
        step();
        drain("stall_drain");

        // Response error latched, later framing error ignored, then cleared.
        issue(32'h3000, 8'd3, '0);
        for (int i = 0; i < 4; i++) begin
            rvalid_i = 1'b1; rlast_i = (i == 3); rresp_i = (i == 1) ? 2'b10 : 2'b00; rand_rdata();
            step();
        end
        rresp_i = 2'b00; rvalid_i = 1'b0; rlast_i = 1'b0;
        check("err_valid_set", err_valid_o, 1);
        check("err_src_rresp", err_src_o, 0);
        check("err_addr_first", err_addr_o, 32'h3000);
        issue(32'h3400, 8'd3, '0);
        for (int i = 0; i < 4; i++) begin
            rvalid_i = 1'b1; rlast_i = (i == 1); rand_rdata();
            step();
        end
        rvalid_i = 1'b0; rlast_i = 1'b0;
        check("err_addr_kept", err_addr_o, 32'h3000);
        check("err_src_kept", err_src_o, 0);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("err_cleared", err_valid_o, 0);

        // Asynchronous reset in the middle of an 8-beat burst.
        issue(32'h6000, 8'd7, '0);
        for (int i = 0; i < 2; i++) begin
            rvalid_i = 1'b1; rlast_i = 1'b0; rand_rdata();
            step();
        end
        rvalid_i = 1'b1;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rvalid_i = 1'b0;
        issue(32'h7000, 8'd1, '0);
        drain("post_rst_drain");
        check("post_rst_err", err_valid_o, 0);

        // Random traffic with occasional errors, clears and long bursts.
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] s;
            req_valid_i = ($urandom_range(0, 1) == 1);
            req_addr_i  = $urandom() & 32'hFFFF_FFC0;
            req_alen_i  = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
            s[31:0]  = $urandom();
            s[63:32] = $urandom();
            req_strb_i  = s;
            arready_i   = ($urandom_range(0, 9) < 7);
            rvalid_i    = ($urandom_range(0, 9) < 6);
            dat_ready_i = ($urandom_range(0, 9) < 7);
            rresp_i     = ($urandom_range(0, 99) < 5) ? 2'($urandom_range(2, 3)) : 2'b00;
            if (bq.size() > 0) rlast_i = (beat == bq[0].alen);
            else               rlast_i = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 99) < 3) rlast_i = ~rlast_i;
            err_clr_i   = ($urandom_range(0, 99) < 2);
            rand_rdata();
            step();
        end
        set_idle();
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_rd_burst_responder.md
# dma_rd_burst_responder

Read-side AXI front end of the DMA that sits between the read streamer and the AXI4 master port. It accepts the streamer's burst requests (addr/alen/size/strb/valid, answered by ready) and issues them on the AR channel, with up to `MAX_OUTSTANDING` bursts in flight. It receives R beats and forwards them as a data stream with per-beat strobe and burst-last. It checks beat count and response codes and latches the first error for the DMA FSM.

## Interface
- `ADDR_W`, 32: address width (`axi_addr_t`).
- `DATA_W`, 512: data width; `DATA_W/8` = 64 byte lanes.
- `LEN_W`, 8: burst length width (`axi_len_t`, beats = alen+1, max 256).
- `MAX_OUTSTANDING`, 4: burst-info FIFO depth, power of two, ≥2.
- `clk`  in  1  clock; `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  burst request valid from streamer.
- `req_addr_i`  in  ADDR_W  burst base address (64B-aligned).
- `req_alen_i`  in  LEN_W  beats-1.
- `req_size_i`  in  3  AXI size, always 6.
- `req_strb_i`  in  DATA_W/8  byte strobe, meaningful only when alen==0.
- `req_ready_o`  out  1  request accepted this cycle when valid&ready.
- `arvalid_o`/`araddr_o`/`arlen_o`/`arsize_o`/`arburst_o`  out  1/ADDR_W/LEN_W/3/2  AXI AR; arburst fixed INCR (2'b01).
- `arready_i`  in  1  AXI AR ready.
- `rvalid_i`/`rdata_i`/`rresp_i`/`rlast_i`  in  1/DATA_W/2/1  AXI R.
- `rready_o`  out  1  AXI R ready.
- `dat_valid_o`/`dat_data_o`/`dat_strb_o`/`dat_last_o`  out  1/DATA_W/DATA_W/8/1  data stream to write side.
- `dat_ready_i`  in  1  data stream ready.
- `busy_o`  out  1  any burst queued, on AR, or outstanding.
- `err_valid_o`/`err_src_o`/`err_addr_o`  out  1/2/ADDR_W  sticky first error.
- `err_clr_i`  in  1  clears error latch.

## Operation
- AR stage: one registered slot. `req_ready_o = (~arvalid_o | arready_i) & ~info_full`. Combinational; never depends on `req_valid_i`.
- On request accept: load the AR slot, set `arvalid_o`, and push {addr, alen, strb} into the burst-info FIFO in the same cycle.
- The AR slot holds stable while `arvalid_o & ~arready_i`. It clears on handshake unless reloaded in the same cycle.
- R path is combinational pass-through:
  - `dat_valid_o = rvalid_i & ~info_empty`
  - `rready_o = dat_ready_i & ~info_empty`
  - `dat_data_o = rdata_i`
- Beat counter `beat_ff` (LEN_W+1 bits) counts R handshakes of the head burst.
- `dat_last_o` = head-burst expected last, i.e. `beat_ff == head.alen`. It does not use `rlast_i`.
- `dat_strb_o`: `head.strb` when `head.alen==0`, else all-ones.
- On the expected-last handshake: pop the FIFO and reset `beat_ff` to 0.
- Error sources (`err_src`), checked only when the latch is empty:
  - `0` = SLVERR/DECERR: `rresp_i[1]` set on any beat.
  - `1` = LAST_EARLY: `rlast_i` before the expected last beat.
  - `2` = LAST_MISSING: expected last beat without `rlast_i`.
- `err_addr_o` = `head.addr` of the failing burst.
- Errors do not stall the data path; beats are still forwarded and counted.
- `err_clr_i` clears the latch next cycle. If an error and a clear coincide, the clear wins and the error is dropped.
- `busy_o = arvalid_o | ~info_empty`.

## Timing
- Reset values:
  - All `*valid_o`, `dat_last_o` and `err_*` outputs are 0; `busy_o`=0.
  - `req_ready_o`=1. `rready_o`=0 because the info FIFO is empty.
  - FIFO pointers and `beat_ff` are 0.
- Latency: request accepted in cycle N gives `arvalid_o` high in N+1. Back-to-back accepts are possible while `arready_i` is held high.
- R→dat latency: 0 cycles.
- FIFO full: the FIFO holds `MAX_OUTSTANDING` entries counting the AR slot. At full, `req_ready_o`=0; it reasserts the cycle after a pop.
- Simultaneous push and pop at full: not allowed, since ready is computed from registered full. Simultaneous push and pop below full: occupancy unchanged.
- R beat arriving with the FIFO empty: not accepted (`rready_o`=0).
- `alen`=255: `beat_ff` reaches 255, and the wrap to 0 happens only via pop.
- Mid-operation reset: all state is discarded immediately. Outstanding AXI bursts are the system's responsibility.

## Structure
- `dma_pkg` holds:
  - `axi_len_t`, `axi_strb_t`, `axi_size_t`, `axi_addr_t`
  - a new `s_dma_burst_info_t` {addr, alen, strb}
  - a new `dma_rd_err_e` {DMA_RRESP_ERR, DMA_LAST_EARLY_ERR, DMA_LAST_MISS_ERR}
  - `AXI_BURST_INCR`.
- One sub-module, `dma_burst_info_fifo`: synchronous FIFO parameterised by depth and type, with full/empty flags, 0-cycle read of the head entry, and registered flags.

## Test plan
- Single burst: addr 0x1000, alen 3, arready=1, four R beats with rlast on the 4th → arvalid for 1 cycle; dat_last only on the 4th beat; strb all-ones; busy drops after the 4th beat.
- Narrow burst: addr 0x2000, alen 0, strb 0x0000_0000_0000_FFF0 → dat_strb_o equals that value; dat_last_o=1.
- Backpressure: MAX_OUTSTANDING=4, arready=1, no R beats, 6 requests → exactly 4 accepted, then req_ready_o=0. After one burst completes, the 5th is accepted one cycle later.
- AR stall: arready=0 for 5 cycles → araddr/arlen stable and arvalid held; req_ready_o=0 while stalled.
- Errors:
  - rresp=2'b10 on beat 1 of the burst at 0x3000 → err_valid=1, src=0, addr=0x3000; data still forwarded.
  - A later rlast-early error → latch unchanged.
  - err_clr_i → err_valid=0.
- Reset mid-burst: rstn low during beat 2 of alen 7 → every output at its reset value in the same cycle; a new burst then completes cleanly.
